// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID stage and the hazard/forwarding control unit.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       i_id_rs1;
  logic [4:0]       i_id_rs2;
  logic [4:0]       i_id_rd;
  logic             i_id_use_rs1;
  logic             i_id_use_rs2;
  logic             i_id_reg_wr;
  logic             i_id_mem_rd;
  logic             i_flush;
  logic             i_mem_busy;

  logic             o_stall_if;
  logic             o_bubble_ex;
  logic             o_frwd_alu_op1;
  logic             o_frwd_alu_op2;
  logic             o_frwd_mem_alu_op1;
  logic             o_frwd_mem_alu_op2;
  logic             o_frwd_mem_op1;
  logic             o_frwd_mem_op2;
  logic [CNT_W-1:0] o_stall_cnt;

  // ID-stage side: presents the decoded instruction, consumes controls
  modport master (
    output i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2,
           i_id_reg_wr, i_id_mem_rd, i_flush, i_mem_busy,
    input  o_stall_if, o_bubble_ex, o_frwd_alu_op1, o_frwd_alu_op2,
           o_frwd_mem_alu_op1, o_frwd_mem_alu_op2, o_frwd_mem_op1,
           o_frwd_mem_op2, o_stall_cnt
  );

  // Hazard unit side
  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rd, i_id_use_rs1, i_id_use_rs2,
           i_id_reg_wr, i_id_mem_rd, i_flush, i_mem_busy,
    output o_stall_if, o_bubble_ex, o_frwd_alu_op1, o_frwd_alu_op2,
           o_frwd_mem_alu_op1, o_frwd_mem_alu_op2, o_frwd_mem_op1,
           o_frwd_mem_op2, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding control for the 5-stage RV32I pipeline: shadows the
// EX/MEM destinations, produces registered one-hot forward selects for the
// instruction leaving ID, detects load-use hazards and counts the bubbles.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  hazard_ctrl_if.slave   bus
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 3;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             ld;
  } slot_t;

  // sel bit order: [0] EX/MEM alu, [1] MEM/WB alu, [2] MEM/WB load data
  slot_t             ex_q, mem_q, id_slot;
  logic [SEL_W-1:0]  fwd1_q, fwd2_q, sel1, sel2;
  logic [CNT_W-1:0]  cnt_q;
  logic              ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic              load_use, bubble, kill;

  // A slot only matches a live, non-x0 destination that the ID operand reads
  function automatic logic hit(slot_t s, logic [REG_W-1:0] rs, logic use_rs);
    return use_rs && (rs != '0) && s.wr && (s.rd == rs);
  endfunction

  // Hazard detection and forward-select priority for the ID instruction
  always_comb begin
    sel1     = '0;
    sel2     = '0;
    ex_hit1  = hit(ex_q,  bus.i_id_rs1, bus.i_id_use_rs1);
    ex_hit2  = hit(ex_q,  bus.i_id_rs2, bus.i_id_use_rs2);
    mem_hit1 = hit(mem_q, bus.i_id_rs1, bus.i_id_use_rs1);
    mem_hit2 = hit(mem_q, bus.i_id_rs2, bus.i_id_use_rs2);
    load_use = ex_q.ld && (ex_hit1 || ex_hit2) && !bus.i_flush;
    bubble   = load_use && !bus.i_mem_busy;
    kill     = load_use || bus.i_flush;
    id_slot  = '{rd: bus.i_id_rd, wr: bus.i_id_reg_wr, ld: bus.i_id_mem_rd};

    if (ex_hit1 && !ex_q.ld) begin
      sel1[0] = 1'b1;
    end else if (mem_hit1) begin
      if (mem_q.ld) sel1[2] = 1'b1;
      else          sel1[1] = 1'b1;
    end

    if (ex_hit2 && !ex_q.ld) begin
      sel2[0] = 1'b1;
    end else if (mem_hit2) begin
      if (mem_q.ld) sel2[2] = 1'b1;
      else          sel2[1] = 1'b1;
    end
  end

  // Pipeline advance; a memory-busy freeze holds every register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q   <= '0;
      mem_q  <= '0;
      fwd1_q <= '0;
      fwd2_q <= '0;
      cnt_q  <= '0;
    end else if (!bus.i_mem_busy) begin
      mem_q <= ex_q;
      if (kill) begin
        ex_q   <= '0;
        fwd1_q <= '0;
        fwd2_q <= '0;
      end else begin
        ex_q   <= id_slot;
        fwd1_q <= sel1;
        fwd2_q <= sel2;
      end
      if (bubble && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Stall/bubble act in the current cycle, so they stay combinational
  assign bus.o_stall_if         = load_use || bus.i_mem_busy;
  assign bus.o_bubble_ex        = bubble;
  assign bus.o_frwd_alu_op1     = fwd1_q[0];
  assign bus.o_frwd_alu_op2     = fwd2_q[0];
  assign bus.o_frwd_mem_alu_op1 = fwd1_q[1];
  assign bus.o_frwd_mem_alu_op2 = fwd2_q[1];
  assign bus.o_frwd_mem_op1     = fwd1_q[2];
  assign bus.o_frwd_mem_op2     = fwd2_q[2];
  assign bus.o_stall_cnt        = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver applies directed and random ID
// traffic and queues the reference model's expected outputs; a negedge
// monitor pops and compares. A second instance with a 2-bit counter shares
// the same stimulus to exercise saturation.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;

  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  hazard_ctrl #(.CNT_W(16)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  hazard_ctrl #(.CNT_W(2))  u_sat (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2));

  assign bus2.i_id_rs1     = bus.i_id_rs1;
  assign bus2.i_id_rs2     = bus.i_id_rs2;
  assign bus2.i_id_rd      = bus.i_id_rd;
  assign bus2.i_id_use_rs1 = bus.i_id_use_rs1;
  assign bus2.i_id_use_rs2 = bus.i_id_use_rs2;
  assign bus2.i_id_reg_wr  = bus.i_id_reg_wr;
  assign bus2.i_id_mem_rd  = bus.i_id_mem_rd;
  assign bus2.i_flush      = bus.i_flush;
  assign bus2.i_mem_busy   = bus.i_mem_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wr, ld, flush, busy;
  } stim_t;

  // fwd order: alu1, alu2, mem_alu1, mem_alu2, mem1, mem2
  typedef struct packed {
    logic        stall_if;
    logic        bubble;
    logic [5:0]  fwd;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  typedef struct {
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_bad = 0;

  // Reference model: the two instructions ahead of ID, and output registers
  instr_t m_ex, m_mem;
  bit [5:0] m_fwd;
  int     m_cnt, m_cnt2;
  stim_t  cur;
  bit     last_stall;

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t alu(int rd, int rs1, int rs2);
    stim_t s = '0;
    s.rd = 5'(rd); s.rs1 = 5'(rs1); s.rs2 = 5'(rs2);
    s.u1 = 1'b1; s.u2 = 1'b1; s.wr = 1'b1;
    return s;
  endfunction

  function automatic stim_t lw(int rd, int rs1);
    stim_t s = '0;
    s.rd = 5'(rd); s.rs1 = 5'(rs1);
    s.u1 = 1'b1; s.wr = 1'b1; s.ld = 1'b1;
    return s;
  endfunction

  // Does an older instruction produce the register this operand reads?
  function automatic bit produces(instr_t p, int rs, bit use_rs);
    return use_rs && rs != 0 && p.wr && p.rd == rs;
  endfunction

  function automatic bit m_load_use(stim_t s);
    return !s.flush && m_ex.ld &&
           (produces(m_ex, int'(s.rs1), s.u1) || produces(m_ex, int'(s.rs2), s.u2));
  endfunction

  // Where the operand value comes from: 0 regfile, 1 alu, 2 mem_alu, 3 mem
  function automatic int source(int rs, bit use_rs);
    if (produces(m_ex, rs, use_rs) && !m_ex.ld) return 1;
    if (produces(m_mem, rs, use_rs)) return m_mem.ld ? 3 : 2;
    return 0;
  endfunction

  function automatic void model_reset();
    m_ex = '{0, 1'b0, 1'b0};
    m_mem = '{0, 1'b0, 1'b0};
    m_fwd = '0;
    m_cnt = 0;
    m_cnt2 = 0;
  endfunction

  function automatic void model_edge(stim_t s);
    bit lu;
    int s1, s2;
    if (s.busy) return;
    lu = m_load_use(s);
    s1 = source(int'(s.rs1), s.u1);
    s2 = source(int'(s.rs2), s.u2);
    if (lu) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_mem = m_ex;
    if (lu || s.flush) begin
      m_ex = '{0, 1'b0, 1'b0};
      m_fwd = '0;
    end else begin
      m_ex = '{int'(s.rd), s.wr, s.ld};
      m_fwd = {s1 == 1, s2 == 1, s1 == 2, s2 == 2, s1 == 3, s2 == 3};
    end
  endfunction

  function automatic exp_t model_out(stim_t s);
    exp_t e;
    bit lu = m_load_use(s);
    e.stall_if = lu || s.busy;
    e.bubble   = lu && !s.busy;
    e.fwd      = m_fwd;
    e.cnt      = 16'(m_cnt);
    e.cnt2     = 2'(m_cnt2);
    return e;
  endfunction

  task automatic compare(exp_t e, string tag);
    exp_t a;
    a.stall_if = bus.o_stall_if;
    a.bubble   = bus.o_bubble_ex;
    a.fwd      = {bus.o_frwd_alu_op1, bus.o_frwd_alu_op2,
                  bus.o_frwd_mem_alu_op1, bus.o_frwd_mem_alu_op2,
                  bus.o_frwd_mem_op1, bus.o_frwd_mem_op2};
    a.cnt      = bus.o_stall_cnt;
    a.cnt2     = bus2.o_stall_cnt;
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t got stall=%b bub=%b fwd=%b cnt=%0d cnt2=%0d, exp stall=%b bub=%b fwd=%b cnt=%0d cnt2=%0d",
               tag, $time, a.stall_if, a.bubble, a.fwd, a.cnt, a.cnt2,
               e.stall_if, e.bubble, e.fwd, e.cnt, e.cnt2);
    end
  endtask

  // One cycle: model follows the edge, then new ID inputs are applied
  task automatic step(stim_t s, bit r);
    exp_t e;
    @(posedge clk);
    if (rst_n) model_edge(cur);
    #1;
    cur = s;
    bus.i_id_rs1     = s.rs1;
    bus.i_id_rs2     = s.rs2;
    bus.i_id_rd      = s.rd;
    bus.i_id_use_rs1 = s.u1;
    bus.i_id_use_rs2 = s.u2;
    bus.i_id_reg_wr  = s.wr;
    bus.i_id_mem_rd  = s.ld;
    bus.i_flush      = s.flush;
    bus.i_mem_busy   = s.busy;
    rst_n            = r;
    if (!r) model_reset();
    e = model_out(s);
    last_stall = e.stall_if;
    exp_q.push_back(e);
  endtask

  // Present an instruction and keep it in ID while the pipeline holds it
  task automatic issue(stim_t s);
    int n = 0;
    step(s, 1'b1);
    while (last_stall && n < 16) begin
      step(s, 1'b1);
      n++;
    end
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) compare(exp_q.pop_front(), "cycle");
    end
  end

  initial begin
    stim_t s;
    exp_t  z;
    rst_n = 1'b0;
    cur = nop();
    model_reset();
    last_stall = 1'b0;
    bus.i_id_rs1 = '0; bus.i_id_rs2 = '0; bus.i_id_rd = '0;
    bus.i_id_use_rs1 = 1'b0; bus.i_id_use_rs2 = 1'b0;
    bus.i_id_reg_wr = 1'b0; bus.i_id_mem_rd = 1'b0;
    bus.i_flush = 1'b0; bus.i_mem_busy = 1'b0;

    step(nop(), 1'b0);
    step(nop(), 1'b0);
    step(nop(), 1'b1);

    // ALU chain
    issue(alu(5, 1, 2)); issue(alu(6, 5, 1)); issue(nop()); issue(nop());
    // Load-use
    issue(lw(7, 1)); issue(alu(8, 7, 7)); issue(nop()); issue(nop());
    // Priority: nearest producer wins
    issue(alu(9, 1, 1)); issue(alu(9, 2, 2)); issue(alu(10, 1, 9));
    issue(nop()); issue(nop());
    // x0 never forwards
    issue(alu(0, 1, 1)); issue(alu(11, 0, 0)); issue(nop()); issue(nop());
    // Freeze with a forward pending
    issue(alu(12, 1, 1)); issue(alu(13, 12, 3));
    s = alu(14, 13, 12);
    s.busy = 1'b1;
    repeat (3) step(s, 1'b1);
    s.busy = 1'b0;
    issue(s); issue(nop()); issue(nop());
    // Flush beats load-use
    issue(lw(7, 1));
    s = alu(8, 7, 1);
    s.flush = 1'b1;
    issue(s); issue(nop()); issue(nop());
    // Saturation of the 2-bit counter
    repeat (5) begin
      issue(lw(7, 1)); issue(alu(8, 7, 2));
    end
    issue(nop());
    // Asynchronous reset in the middle of a stall
    issue(lw(7, 1));
    step(alu(8, 7, 7), 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    z = model_out(cur);
    compare(z, "async_reset");
    step(nop(), 1'b0);
    step(nop(), 1'b1);
    issue(alu(3, 1, 1)); issue(alu(4, 3, 3)); issue(nop());

    // Random traffic following pipeline hold/flush semantics
    for (int i = 0; i < 600; i++) begin
      bit held;
      held = last_stall && !(cur.flush && !cur.busy);
      if (held) begin
        s = cur;
      end else begin
        s = '0;
        s.rs1 = 5'($urandom_range(0, 4));
        s.rs2 = 5'($urandom_range(0, 4));
        s.rd  = 5'($urandom_range(0, 4));
        s.u1  = 1'($urandom_range(0, 3) != 0);
        s.u2  = 1'($urandom_range(0, 1));
        s.wr  = 1'($urandom_range(0, 3) != 0);
        s.ld  = s.wr && ($urandom_range(0, 2) == 0);
      end
      s.flush = (cur.busy && cur.flush) ? 1'b1 : 1'($urandom_range(0, 9) == 0);
      s.busy  = 1'($urandom_range(0, 4) == 0);
      step(s, 1'b1);
    end

    step(nop(), 1'b1);
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending, exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
